// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM master-side bundle for one requester of onchip_mem_arbiter.
// Handshake: a request (read|write) is accepted in the cycle where waitrequest=0; while waitrequest=1 the master holds every request field stable. Read data arrives later, qualified by readdatavalid.
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port on-chip RAM, with in-order read return.
// Define OCM_ARB_FIXED_PRIO_EN for strict m0-over-m1 priority instead of round-robin.
module onchip_mem_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  onchip_mem_arbiter_if.slave    m0,
  onchip_mem_arbiter_if.slave    m1,
  output logic [ADDR_W-1:0]      mem_address,
  output logic [DATA_W/8-1:0]    mem_byteenable,
  output logic                   mem_chipselect,
  output logic                   mem_write,
  output logic [DATA_W-1:0]      mem_writedata,
  output logic                   mem_clken,
  input  logic [DATA_W-1:0]      mem_readdata,
  output logic                   dbg_state,
  output logic                   dbg_last_gnt
);
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t state, state_next;
  logic   ready;
  logic   last_gnt;
  logic   req0, req1;
  logic   gnt0, gnt1;
  logic   acc_rd;

  logic [READ_LATENCY-1:0] rd_vld;
  logic [READ_LATENCY-1:0] rd_own;
  logic                    rsp_vld;
  logic                    rsp_own;

  // Hold off all accepts for one edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
    endcase
  end

  assign ready     = (state == ST_RUN);
  assign dbg_state = state;

  assign req0 = ready & (m0.read | m0.write);
  assign req1 = ready & (m1.read | m1.write);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
`ifdef OCM_ARB_FIXED_PRIO_EN
    gnt0 = req0;
    gnt1 = req1 & ~req0;
`else
    if (req0 && req1) begin
      // last_gnt=1 means m1 went last, so m0 takes the tie.
      gnt0 = last_gnt;
      gnt1 = ~last_gnt;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
`endif
  end

  // A simultaneous read+write from one master is a write with no response.
  always_comb begin
    mem_address    = m0.address;
    mem_byteenable = m0.byteenable;
    mem_writedata  = m0.writedata;
    mem_write      = gnt0 & m0.write;
    acc_rd         = gnt0 & m0.read & ~m0.write;
    if (gnt1) begin
      mem_address    = m1.address;
      mem_byteenable = m1.byteenable;
      mem_writedata  = m1.writedata;
      mem_write      = m1.write;
      acc_rd         = m1.read & ~m1.write;
    end
  end

  assign mem_chipselect = gnt0 | gnt1;
  assign mem_clken      = 1'b1;

  assign m0.waitrequest = ~gnt0;
  assign m1.waitrequest = ~gnt1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            last_gnt <= 1'b1;
    else if (mem_chipselect) last_gnt <= gnt1;
  end

  assign dbg_last_gnt = last_gnt;

  // Read tracking pipeline: one {valid, owner} slot per cycle of RAM latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld <= '0;
      rd_own <= '0;
    end else begin
      rd_vld[0] <= acc_rd;
      rd_own[0] <= gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        rd_own[i] <= rd_own[i-1];
      end
    end
  end

  assign rsp_vld = rd_vld[READ_LATENCY-1];
  assign rsp_own = rd_own[READ_LATENCY-1];

  assign m0.readdatavalid = rsp_vld & ~rsp_own;
  assign m1.readdatavalid = rsp_vld &  rsp_own;
  assign m0.readdata      = (rsp_vld && !rsp_own) ? mem_readdata : '0;
  assign m1.readdata      = (rsp_vld &&  rsp_own) ? mem_readdata : '0;
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench for onchip_mem_arbiter: directed scenarios plus random traffic against a
// transaction-level memory/arbitration model with a RAM behavioural model on the slave side.
module tb_onchip_mem_arbiter;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int RL     = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  logic              dbg_state;
  logic              dbg_last_gnt;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .dbg_state      (dbg_state),
    .dbg_last_gnt   (dbg_last_gnt)
  );

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_d,
                                              input logic [DATA_W-1:0] new_d,
                                              input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_d;
    for (int b = 0; b < BE_W; b++) if (be[b]) r[8*b +: 8] = new_d[8*b +: 8];
    return r;
  endfunction

  // ---------------- RAM behavioural model ----------------
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_q1 = '0;
  logic [DATA_W-1:0] ram_q2 = '0;
  initial for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      else           ram_q1 <= ram[mem_address];
    end
    ram_q2 <= ram_q1;
  end
  assign mem_readdata = (RL == 2) ? ram_q2 : ram_q1;

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data;
  } tx_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_gnt_m = 1;
  tx_t txq0[$];
  tx_t txq1[$];
  logic [64:0] exp_q[$];            // {owner, due cycle[31:0], data[31:0]}
  logic [DATA_W-1:0] gold [int];
  int gnt_log[$];
  int rsp_own_log[$];
  int rsp_cyc_log[$];
  logic [DATA_W-1:0] last_rd0, last_rd1;

  function automatic logic [DATA_W-1:0] gold_rd(input logic [ADDR_W-1:0] a);
    return gold.exists(int'(a)) ? gold[int'(a)] : '0;
  endfunction

  function automatic tx_t mk(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                             input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    tx_t t;
    t.rd = rd; t.wr = wr; t.addr = a; t.be = be; t.data = d;
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive();
    tx_t t;
    t = (txq0.size() > 0) ? txq0[0] : mk(1'b0, 1'b0, '0, '0, '0);
    m0_if.read = t.rd; m0_if.write = t.wr; m0_if.address = t.addr;
    m0_if.byteenable = t.be; m0_if.writedata = t.data;
    t = (txq1.size() > 0) ? txq1[0] : mk(1'b0, 1'b0, '0, '0, '0);
    m1_if.read = t.rd; m1_if.write = t.wr; m1_if.address = t.addr;
    m1_if.byteenable = t.be; m1_if.writedata = t.data;
  endtask

  // One clock cycle: drive heads, check at negedge against the model, advance the model.
  task automatic step();
    tx_t t0, t1, t;
    bit r0, r1;
    int w;
    logic [64:0] e;
    logic ev0, ev1;
    logic [DATA_W-1:0] ed0, ed1;
    logic [31:0] due;
    drive();
    @(negedge clk);
    t0 = (txq0.size() > 0) ? txq0[0] : mk(1'b0, 1'b0, '0, '0, '0);
    t1 = (txq1.size() > 0) ? txq1[0] : mk(1'b0, 1'b0, '0, '0, '0);
    r0 = t0.rd | t0.wr;
    r1 = t1.rd | t1.wr;
    w = -1;
    if (r0 && r1) begin
`ifdef OCM_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = (last_gnt_m == 0) ? 1 : 0;
`endif
    end else if (r0) w = 0;
    else if (r1) w = 1;

    check("wait0", m0_if.waitrequest, w != 0);
    check("wait1", m1_if.waitrequest, w != 1);
    check("chipselect", mem_chipselect, w >= 0);
    if (w >= 0) begin
      t = (w == 1) ? t1 : t0;
      check("mem_write", mem_write, t.wr);
      check("mem_address", mem_address, t.addr);
      if (t.wr) begin
        check("mem_writedata", mem_writedata, t.data);
        check("mem_byteenable", mem_byteenable, t.be);
      end
    end
    if (!m0_if.waitrequest) gnt_log.push_back(0);
    if (!m1_if.waitrequest) gnt_log.push_back(1);

    ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
    if (exp_q.size() > 0 && exp_q[0][63:32] == 32'(cyc)) begin
      e = exp_q.pop_front();
      if (e[64]) begin ev1 = 1'b1; ed1 = e[31:0]; end
      else       begin ev0 = 1'b1; ed0 = e[31:0]; end
    end
    check("rdv0", m0_if.readdatavalid, ev0);
    check("rdv1", m1_if.readdatavalid, ev1);
    check("readdata0", m0_if.readdata, ed0);
    check("readdata1", m1_if.readdata, ed1);
    if (m0_if.readdatavalid) begin
      last_rd0 = m0_if.readdata; rsp_own_log.push_back(0); rsp_cyc_log.push_back(cyc);
    end
    if (m1_if.readdatavalid) begin
      last_rd1 = m1_if.readdata; rsp_own_log.push_back(1); rsp_cyc_log.push_back(cyc);
    end

    if (w >= 0) begin
      t = (w == 1) ? t1 : t0;
      last_gnt_m = w;
      if (t.wr) gold[int'(t.addr)] = merge(gold_rd(t.addr), t.data, t.be);
      else begin
        due = 32'(cyc + RL);
        exp_q.push_back({w[0], due, gold_rd(t.addr)});
      end
    end
    if (txq0.size() > 0 && (w == 0 || !r0)) void'(txq0.pop_front());
    if (txq1.size() > 0 && (w == 1 || !r1)) void'(txq1.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((txq0.size() + txq1.size() + exp_q.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", txq0.size() + txq1.size() + exp_q.size(), 0);
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int k;
    m0_if.read = 1'b1; m0_if.write = 1'b0; m0_if.address = '0;
    m0_if.byteenable = '1; m0_if.writedata = '0;
    m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = '0;
    m1_if.byteenable = '0; m1_if.writedata = '0;
    last_rd0 = '0; last_rd1 = '0;

    // Reset with m0 already requesting.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wait0", m0_if.waitrequest, 1);
    check("rst_wait1", m1_if.waitrequest, 1);
    check("rst_cs", mem_chipselect, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_rdv0", m0_if.readdatavalid, 0);
    check("rst_rdv1", m1_if.readdatavalid, 0);
    check("rst_readdata0", m0_if.readdata, 0);
    check("rst_state", dbg_state, 0);
    check("rst_last_gnt", dbg_last_gnt, 1);
    check("clken", mem_clken, 1);
    reset_n = 1'b1;
    #1;
    check("post_release_wait0", m0_if.waitrequest, 1);
    @(posedge clk);
    #1;
    check("ready_state", dbg_state, 1);
    txq0.push_back(mk(1'b1, 1'b0, 15'h0000, 4'hF, '0));
    run(20);

    // Write then read back.
    last_rd0 = '0;
    txq0.push_back(mk(1'b0, 1'b1, 15'h0010, 4'hF, 32'hDEADBEEF));
    txq0.push_back(mk(1'b1, 1'b0, 15'h0010, 4'hF, '0));
    run(20);
    check("wr_rd_data", last_rd0, 32'hDEADBEEF);

    // Byte lanes.
    last_rd0 = '0;
    txq0.push_back(mk(1'b0, 1'b1, 15'h0100, 4'hF, 32'h11223344));
    txq0.push_back(mk(1'b0, 1'b1, 15'h0100, 4'h8, 32'hAA000000));
    txq0.push_back(mk(1'b1, 1'b0, 15'h0100, 4'hF, '0));
    run(20);
    check("byte_lane", last_rd0, 32'hAA223344);

    // Read and write together behave as a write.
    last_rd0 = '0;
    rsp_own_log.delete();
    txq0.push_back(mk(1'b1, 1'b1, 15'h0200, 4'hF, 32'h5A5A5A5A));
    run(20);
    check("rdwr_no_resp", rsp_own_log.size(), 0);
    txq0.push_back(mk(1'b1, 1'b0, 15'h0200, 4'hF, '0));
    run(20);
    check("rdwr_written", last_rd0, 32'h5A5A5A5A);

    // Reset between acceptance and response of an m1 read.
    rsp_own_log.delete();
    txq1.push_back(mk(1'b1, 1'b0, 15'h0010, 4'hF, '0));
    step();
    exp_q.delete();
    reset_n = 1'b0;
    last_gnt_m = 1;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (3) step();
    check("reset_drop_resp", rsp_own_log.size(), 0);
    check("reset_last_gnt", dbg_last_gnt, 1);

    // Written data survives reset.
    last_rd1 = '0;
    txq1.push_back(mk(1'b1, 1'b0, 15'h0010, 4'hF, '0));
    run(20);
    check("persist_data", last_rd1, 32'hDEADBEEF);

    // Continuous contention: 8 reads each.
    gnt_log.delete(); rsp_own_log.delete(); rsp_cyc_log.delete();
    for (int i = 0; i < 8; i++) begin
      txq0.push_back(mk(1'b1, 1'b0, 15'($urandom_range(0, 255)), 4'hF, '0));
      txq1.push_back(mk(1'b1, 1'b0, 15'($urandom_range(0, 255)), 4'hF, '0));
    end
    run(60);
    check("contention_grants", gnt_log.size(), 16);
    check("contention_resps", rsp_own_log.size(), 16);
    for (int i = 0; i < 16 && i < gnt_log.size() && i < rsp_own_log.size(); i++) begin
`ifdef OCM_ARB_FIXED_PRIO_EN
      k = (i < 8) ? 0 : 1;
`else
      k = i % 2;
`endif
      check($sformatf("grant_order_%0d", i), gnt_log[i], k);
      check($sformatf("resp_owner_%0d", i), rsp_own_log[i], k);
      check($sformatf("resp_gap_%0d", i), rsp_cyc_log[i] - rsp_cyc_log[0], i);
    end

    // Random traffic with idles, narrow address range to force reuse.
    for (int i = 0; i < 150; i++) begin
      for (int m = 0; m < 2; m++) begin
        tx_t t;
        k = $urandom_range(0, 9);
        t = mk(k inside {[3:6], 9}, k inside {[7:9]}, 15'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), $urandom());
        if (m == 0) txq0.push_back(t);
        else        txq1.push_back(t);
      end
    end
    run(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
